// File: rtl/mercury_decode.sv
// mercury_decode: RV64I instruction decode stage with a main + skid output buffer.
// Build option: define MERCURY_DECODE_RV64_EN for the RV64-only encodings (default is the RV32I subset).
package mercury_decode_pkg;

   typedef enum logic [5:0] {
      NONE,
      LUI, AUIPC, JAL, JALR,
      BEQ, BNE, BLT, BGE, BLTU, BGEU,
      LB, LH, LW, LBU, LHU, LWU, LD,
      SB, SH, SW, SD,
      ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
      ADDIW, SLLIW, SRLIW, SRAIW,
      ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
      ADDW, SUBW, SLLW, SRLW, SRAW,
      FENCE, FENCE_TSO, PAUSE, ENV
   } opcode1_t;

   typedef struct packed {
      logic [4:0] lsrc1;
      logic [4:0] lsrc2;
      logic [4:0] ldst;
   } uop_info_t;

endpackage

module mercury_decode
   import mercury_decode_pkg::*;
#(
   parameter int PC_W = 64
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush_i,
   input  logic            ifu_valid_i,
   output logic            ifu_ready_o,
   input  logic [31:0]     ifu_inst_i,
   input  logic [PC_W-1:0] ifu_pc_i,
   output logic            dec_valid_o,
   input  logic            dec_ready_i,
   output opcode1_t        dec_opcode_o,
   output uop_info_t       dec_uop_o,
   output logic [63:0]     dec_imm_o,
   output logic [PC_W-1:0] dec_pc_o,
   output logic            dec_illegal_o
);

`ifdef MERCURY_DECODE_RV64_EN
   localparam logic RV64 = 1'b1;
`else
   localparam logic RV64 = 1'b0;
`endif

   typedef enum logic [3:0] {
      FMT_X, FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_FENCE, FMT_ENV
   } fmt_t;

   typedef struct packed {
      opcode1_t        opcode;
      uop_info_t       uop;
      logic [63:0]     imm;
      logic [PC_W-1:0] pc;
      logic            illegal;
   } entry_t;

   localparam entry_t ENTRY_RST = '{opcode: NONE, uop: '0, imm: '0, pc: '0, illegal: 1'b0};

   logic [6:0] op;
   logic [2:0] f3;
   logic [6:0] f7;
   logic [5:0] shamt;
   logic       shamt_ok;

   assign op       = ifu_inst_i[6:0];
   assign f3       = ifu_inst_i[14:12];
   assign f7       = ifu_inst_i[31:25];
   assign shamt    = RV64 ? ifu_inst_i[25:20] : {1'b0, ifu_inst_i[24:20]};
   // shamt[5] is only meaningful on RV64; on RV32 a set bit 25 makes the shift illegal.
   assign shamt_ok = RV64 | ~ifu_inst_i[25];

   opcode1_t  dec_opc;
   fmt_t      fmt;
   logic      is_shift;
   uop_info_t dec_uop;
   logic [63:0] dec_imm;
   logic      dec_illegal;

   always_comb begin
      dec_opc  = NONE;
      fmt      = FMT_X;
      is_shift = 1'b0;
      case (op)
         7'b0110111: begin fmt = FMT_U; dec_opc = LUI;   end
         7'b0010111: begin fmt = FMT_U; dec_opc = AUIPC; end
         7'b1101111: begin fmt = FMT_J; dec_opc = JAL;   end
         7'b1100111: begin
            fmt = FMT_I;
            if (f3 == 3'b000) dec_opc = JALR;
         end
         7'b1100011: begin
            fmt = FMT_B;
            case (f3)
               3'b000:  dec_opc = BEQ;
               3'b001:  dec_opc = BNE;
               3'b100:  dec_opc = BLT;
               3'b101:  dec_opc = BGE;
               3'b110:  dec_opc = BLTU;
               3'b111:  dec_opc = BGEU;
               default: dec_opc = NONE;
            endcase
         end
         7'b0000011: begin
            fmt = FMT_I;
            case (f3)
               3'b000:  dec_opc = LB;
               3'b001:  dec_opc = LH;
               3'b010:  dec_opc = LW;
               3'b011:  if (RV64) dec_opc = LD;
               3'b100:  dec_opc = LBU;
               3'b101:  dec_opc = LHU;
               3'b110:  if (RV64) dec_opc = LWU;
               default: dec_opc = NONE;
            endcase
         end
         7'b0100011: begin
            fmt = FMT_S;
            case (f3)
               3'b000:  dec_opc = SB;
               3'b001:  dec_opc = SH;
               3'b010:  dec_opc = SW;
               3'b011:  if (RV64) dec_opc = SD;
               default: dec_opc = NONE;
            endcase
         end
         7'b0010011: begin
            fmt = FMT_I;
            case (f3)
               3'b000: dec_opc = ADDI;
               3'b010: dec_opc = SLTI;
               3'b011: dec_opc = SLTIU;
               3'b100: dec_opc = XORI;
               3'b110: dec_opc = ORI;
               3'b111: dec_opc = ANDI;
               3'b001: begin
                  is_shift = 1'b1;
                  if (ifu_inst_i[31:26] == 6'b000000 && shamt_ok) dec_opc = SLLI;
               end
               default: begin
                  is_shift = 1'b1;
                  if (shamt_ok && ifu_inst_i[31:26] == 6'b000000) dec_opc = SRLI;
                  else if (shamt_ok && ifu_inst_i[31:26] == 6'b010000) dec_opc = SRAI;
               end
            endcase
         end
         7'b0011011: begin
            fmt = FMT_I;
            if (RV64) begin
               case (f3)
                  3'b000: dec_opc = ADDIW;
                  3'b001: begin
                     is_shift = 1'b1;
                     if (f7 == 7'b0000000) dec_opc = SLLIW;
                  end
                  3'b101: begin
                     is_shift = 1'b1;
                     if (f7 == 7'b0000000) dec_opc = SRLIW;
                     else if (f7 == 7'b0100000) dec_opc = SRAIW;
                  end
                  default: dec_opc = NONE;
               endcase
            end
         end
         7'b0110011: begin
            fmt = FMT_R;
            case ({f7, f3})
               10'b0000000_000: dec_opc = ADD;
               10'b0100000_000: dec_opc = SUB;
               10'b0000000_001: dec_opc = SLL;
               10'b0000000_010: dec_opc = SLT;
               10'b0000000_011: dec_opc = SLTU;
               10'b0000000_100: dec_opc = XOR;
               10'b0000000_101: dec_opc = SRL;
               10'b0100000_101: dec_opc = SRA;
               10'b0000000_110: dec_opc = OR;
               10'b0000000_111: dec_opc = AND;
               default:         dec_opc = NONE;
            endcase
         end
         7'b0111011: begin
            fmt = FMT_R;
            if (RV64) begin
               case ({f7, f3})
                  10'b0000000_000: dec_opc = ADDW;
                  10'b0100000_000: dec_opc = SUBW;
                  10'b0000000_001: dec_opc = SLLW;
                  10'b0000000_101: dec_opc = SRLW;
                  10'b0100000_101: dec_opc = SRAW;
                  default:         dec_opc = NONE;
               endcase
            end
         end
         7'b0001111: begin
            fmt = FMT_FENCE;
            if (f3 == 3'b000) begin
               if (ifu_inst_i[31:20] == 12'h833)
                  dec_opc = FENCE_TSO;
               else if (ifu_inst_i[31:20] == 12'h010 && ifu_inst_i[19:15] == 5'd0 &&
                        ifu_inst_i[11:7] == 5'd0)
                  dec_opc = PAUSE;
               else
                  dec_opc = FENCE;
            end
         end
         7'b1110011: begin fmt = FMT_ENV; dec_opc = ENV; end
         default:    dec_opc = NONE;
      endcase
   end

   assign dec_illegal = (dec_opc == NONE);

   // Operand fields follow the major-opcode format even for illegal encodings.
   always_comb begin
      dec_uop = '{lsrc1: ifu_inst_i[19:15], lsrc2: ifu_inst_i[24:20], ldst: ifu_inst_i[11:7]};
      dec_imm = '0;
      case (fmt)
         FMT_I: begin
            dec_uop.lsrc2 = '0;
            dec_imm = is_shift ? {58'd0, shamt} : {{52{ifu_inst_i[31]}}, ifu_inst_i[31:20]};
         end
         FMT_S: begin
            dec_uop.ldst = '0;
            dec_imm = {{52{ifu_inst_i[31]}}, ifu_inst_i[31:25], ifu_inst_i[11:7]};
         end
         FMT_B: begin
            dec_uop.ldst = '0;
            dec_imm = {{51{ifu_inst_i[31]}}, ifu_inst_i[31], ifu_inst_i[7],
                       ifu_inst_i[30:25], ifu_inst_i[11:8], 1'b0};
         end
         FMT_U: begin
            dec_uop.lsrc1 = '0;
            dec_uop.lsrc2 = '0;
            dec_imm = {{32{ifu_inst_i[31]}}, ifu_inst_i[31:12], 12'd0};
         end
         FMT_J: begin
            dec_uop.lsrc1 = '0;
            dec_uop.lsrc2 = '0;
            dec_imm = {{43{ifu_inst_i[31]}}, ifu_inst_i[31], ifu_inst_i[19:12],
                       ifu_inst_i[20], ifu_inst_i[30:21], 1'b0};
         end
         FMT_FENCE, FMT_ENV: begin
            dec_uop.lsrc2 = '0;
            dec_uop.ldst  = '0;
         end
         default: dec_imm = '0;
      endcase
   end

   // Handshake: a transfer happens on an edge where valid and ready are both high;
   // valid never depends on ready, and ifu_ready_o comes straight from a flop.
   entry_t new_e, main_q, skid_q;
   logic   main_v, skid_v, ready_q;
   logic   accept, drain, skid_v_nx;

   always_comb begin
      new_e = '{opcode: dec_opc, uop: dec_uop, imm: dec_imm, pc: ifu_pc_i, illegal: dec_illegal};
   end

   assign accept    = ifu_valid_i & ready_q;
   assign drain     = main_v & dec_ready_i;
   assign skid_v_nx = skid_v ? (~drain | accept) : (accept & main_v & ~drain);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_q  <= ENTRY_RST;
         skid_q  <= ENTRY_RST;
         main_v  <= 1'b0;
         skid_v  <= 1'b0;
         ready_q <= 1'b1;
      end else if (flush_i) begin
         main_v  <= 1'b0;
         skid_v  <= 1'b0;
         ready_q <= 1'b1;
      end else begin
         skid_v  <= skid_v_nx;
         ready_q <= ~skid_v_nx;
         if (skid_v && drain) begin
            main_q <= skid_q;
         end else if (accept && (!main_v || drain)) begin
            main_q <= new_e;
            main_v <= 1'b1;
         end else if (drain) begin
            main_v <= 1'b0;
         end
         if (accept && main_v && !(drain && !skid_v))
            skid_q <= new_e;
      end
   end

   assign ifu_ready_o   = ready_q;
   assign dec_valid_o   = main_v;
   assign dec_opcode_o  = main_q.opcode;
   assign dec_uop_o     = main_q.uop;
   assign dec_imm_o     = main_q.imm;
   assign dec_pc_o      = main_q.pc;
   assign dec_illegal_o = main_q.illegal;

endmodule

// File: tb/tb_mercury_decode.sv
// Directed self-checking bench for mercury_decode: decode vectors, backpressure, flush, reset.
module tb_mercury_decode;
   import mercury_decode_pkg::*;

   localparam int PC_W = 64;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            flush_i = 1'b0;
   logic            ifu_valid_i = 1'b0;
   logic            ifu_ready_o;
   logic [31:0]     ifu_inst_i = '0;
   logic [PC_W-1:0] ifu_pc_i = '0;
   logic            dec_valid_o;
   logic            dec_ready_i = 1'b1;
   opcode1_t        dec_opcode_o;
   uop_info_t       dec_uop_o;
   logic [63:0]     dec_imm_o;
   logic [PC_W-1:0] dec_pc_o;
   logic            dec_illegal_o;

   int checks = 0;
   int fails  = 0;

   typedef struct {
      logic [31:0] inst;
      opcode1_t    opc;
      logic [4:0]  l1;
      logic [4:0]  l2;
      logic [4:0]  ld;
      logic [63:0] imm;
      logic        ill;
   } vec_t;

   mercury_decode #(.PC_W(PC_W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .flush_i      (flush_i),
      .ifu_valid_i  (ifu_valid_i),
      .ifu_ready_o  (ifu_ready_o),
      .ifu_inst_i   (ifu_inst_i),
      .ifu_pc_i     (ifu_pc_i),
      .dec_valid_o  (dec_valid_o),
      .dec_ready_i  (dec_ready_i),
      .dec_opcode_o (dec_opcode_o),
      .dec_uop_o    (dec_uop_o),
      .dec_imm_o    (dec_imm_o),
      .dec_pc_o     (dec_pc_o),
      .dec_illegal_o(dec_illegal_o)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      checks++;
      if (dec_valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", dec_valid_o); end
      checks++;
      if (ifu_ready_o !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", ifu_ready_o); end
      checks++;
      if (dec_opcode_o !== NONE) begin fails++; $display("FAIL reset_opcode: got %0d want NONE", dec_opcode_o); end
      checks++;
      if ({dec_uop_o, dec_imm_o, dec_pc_o, dec_illegal_o} !== '0) begin
         fails++;
         $display("FAIL reset_fields: got uop=%h imm=%h pc=%h ill=%b want all 0", dec_uop_o, dec_imm_o, dec_pc_o, dec_illegal_o);
      end
      rst_n = 1'b1;
      tick();
      checks++;
      if (dec_valid_o !== 1'b0) begin fails++; $display("FAIL reset_release_valid: got %b want 0", dec_valid_o); end
   endtask

   // Issues one vector per cycle with dec_ready_i high, so this is also the back-to-back check.
   task automatic test_decode();
      vec_t v[$];
      logic [150:0] got, exp;
      logic [PC_W-1:0] pc;
      v.push_back('{32'hfff10093, ADDI,      5'd2,  5'd0, 5'd1,  64'hFFFF_FFFF_FFFF_FFFF, 1'b0});
      v.push_back('{32'h00532423, SW,        5'd6,  5'd5, 5'd0,  64'd8,                   1'b0});
      v.push_back('{32'h00000000, NONE,      5'd0,  5'd0, 5'd0,  64'd0,                   1'b1});
      v.push_back('{32'h800082B7, LUI,       5'd0,  5'd0, 5'd5,  64'hFFFF_FFFF_8000_8000, 1'b0});
      v.push_back('{32'hFFFFF117, AUIPC,     5'd0,  5'd0, 5'd2,  64'hFFFF_FFFF_FFFF_F000, 1'b0});
      v.push_back('{32'hFFDFF0EF, JAL,       5'd0,  5'd0, 5'd1,  64'hFFFF_FFFF_FFFF_FFFC, 1'b0});
      v.push_back('{32'h004280E7, JALR,      5'd5,  5'd0, 5'd1,  64'd4,                   1'b0});
      v.push_back('{32'h00419863, BNE,       5'd3,  5'd4, 5'd0,  64'd16,                  1'b0});
      v.push_back('{32'hFE20FFE3, BGEU,      5'd1,  5'd2, 5'd0,  64'hFFFF_FFFF_FFFF_FFFE, 1'b0});
      v.push_back('{32'h8005C503, LBU,       5'd11, 5'd0, 5'd10, 64'hFFFF_FFFF_FFFF_F800, 1'b0});
      v.push_back('{32'h409403B3, SUB,       5'd8,  5'd9, 5'd7,  64'd0,                   1'b0});
      v.push_back('{32'h029403B3, NONE,      5'd8,  5'd9, 5'd7,  64'd0,                   1'b1});
      v.push_back('{32'h41F15093, SRAI,      5'd2,  5'd0, 5'd1,  64'd31,                  1'b0});
      v.push_back('{32'h4211509B, NONE,      5'd2,  5'd0, 5'd1,  64'd0,                   1'b1});
      v.push_back('{32'h8330000F, FENCE_TSO, 5'd0,  5'd0, 5'd0,  64'd0,                   1'b0});
      v.push_back('{32'h0FF0000F, FENCE,     5'd0,  5'd0, 5'd0,  64'd0,                   1'b0});
      v.push_back('{32'h00000073, ENV,       5'd0,  5'd0, 5'd0,  64'd0,                   1'b0});
`ifdef MERCURY_DECODE_RV64_EN
      v.push_back('{32'h00023183, LD,        5'd4,  5'd0, 5'd3,  64'd0,                   1'b0});
      v.push_back('{32'h02015093, SRLI,      5'd2,  5'd0, 5'd1,  64'd32,                  1'b0});
      v.push_back('{32'h003100BB, ADDW,      5'd2,  5'd3, 5'd1,  64'd0,                   1'b0});
`else
      v.push_back('{32'h00023183, NONE,      5'd4,  5'd0, 5'd3,  64'd0,                   1'b1});
      v.push_back('{32'h02015093, NONE,      5'd2,  5'd0, 5'd1,  64'd0,                   1'b1});
      v.push_back('{32'h003100BB, NONE,      5'd2,  5'd3, 5'd1,  64'd0,                   1'b1});
`endif
      dec_ready_i = 1'b1;
      foreach (v[i]) begin
         pc = 64'h1000 + 64'(i * 4);
         ifu_valid_i = 1'b1;
         ifu_inst_i  = v[i].inst;
         ifu_pc_i    = pc;
         for (int n = 0; n < 20 && !ifu_ready_o; n++) tick();
         checks++;
         if (ifu_ready_o !== 1'b1) begin fails++; $display("FAIL decode_ready_timeout: got %b want 1", ifu_ready_o); end
         tick();
         checks++;
         if (v[i].ill) begin
            got = {dec_valid_o, dec_opcode_o, 15'd0, 64'd0, dec_pc_o, dec_illegal_o};
            exp = {1'b1, v[i].opc, 15'd0, 64'd0, pc, 1'b1};
         end else begin
            got = {dec_valid_o, dec_opcode_o, dec_uop_o, dec_imm_o, dec_pc_o, dec_illegal_o};
            exp = {1'b1, v[i].opc, v[i].l1, v[i].l2, v[i].ld, v[i].imm, pc, 1'b0};
         end
         if (got !== exp) begin
            fails++;
            $display("FAIL decode_%08h: got %h want %h", v[i].inst, got, exp);
         end
      end
      ifu_valid_i = 1'b0;
      tick();
      checks++;
      if (dec_valid_o !== 1'b0) begin fails++; $display("FAIL decode_idle: got %b want 0", dec_valid_o); end
   endtask

   task automatic test_backpressure();
      logic [PC_W-1:0] exp_q[$];
      logic [31:0] insts[4];
      int idx = 0;
      int delivered = 0;
      logic acc, drn;
      insts[0] = 32'h00100093;
      insts[1] = 32'h00200113;
      insts[2] = 32'h00300193;
      insts[3] = 32'h00400213;
      for (int k = 0; k < 14; k++) begin
         dec_ready_i = (k >= 4);
         ifu_valid_i = (idx < 4);
         ifu_inst_i  = (idx < 4) ? insts[idx] : 32'd0;
         ifu_pc_i    = 64'h2000 + 64'(idx * 4);
         acc = ifu_valid_i & ifu_ready_o;
         drn = dec_valid_o & dec_ready_i;
         if (drn) begin
            checks++;
            if (exp_q.size() == 0 || dec_pc_o !== exp_q[0]) begin
               fails++;
               $display("FAIL bp_order: got pc %h want %h", dec_pc_o, (exp_q.size() != 0) ? exp_q[0] : '1);
            end
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            delivered++;
         end
         if (k >= 2 && k <= 4) begin
            checks++;
            if (ifu_ready_o !== 1'b0) begin fails++; $display("FAIL bp_ready_low cycle %0d: got %b want 0", k, ifu_ready_o); end
         end
         if (k >= 1 && k <= 4) begin
            checks++;
            if (dec_valid_o !== 1'b1 || dec_pc_o !== 64'h2000) begin
               fails++;
               $display("FAIL bp_hold cycle %0d: got valid=%b pc=%h want 1 2000", k, dec_valid_o, dec_pc_o);
            end
         end
         if (k >= 4 && k <= 7) begin
            checks++;
            if (drn !== 1'b1) begin fails++; $display("FAIL bp_throughput cycle %0d: got %b want 1", k, drn); end
         end
         if (k == 4) begin
            checks++;
            if (idx !== 2) begin fails++; $display("FAIL bp_accepted: got %0d want 2", idx); end
         end
         if (acc) begin
            exp_q.push_back(ifu_pc_i);
            idx++;
         end
         tick();
      end
      ifu_valid_i = 1'b0;
      checks++;
      if (delivered !== 4 || exp_q.size() != 0) begin
         fails++;
         $display("FAIL bp_delivered: got %0d left %0d want 4 left 0", delivered, exp_q.size());
      end
   endtask

   task automatic test_flush();
      dec_ready_i = 1'b0;
      ifu_valid_i = 1'b1;
      ifu_inst_i  = 32'h00500293;
      ifu_pc_i    = 64'h3000;
      tick();
      ifu_pc_i = 64'h3004;
      flush_i  = 1'b1;
      tick();
      flush_i = 1'b0;
      checks++;
      if (dec_valid_o !== 1'b0 || ifu_ready_o !== 1'b1) begin
         fails++;
         $display("FAIL flush_main: got valid=%b ready=%b want 0 1", dec_valid_o, ifu_ready_o);
      end
      ifu_pc_i = 64'h3008;
      tick();
      ifu_pc_i = 64'h300C;
      tick();
      checks++;
      if (dec_valid_o !== 1'b1 || ifu_ready_o !== 1'b0) begin
         fails++;
         $display("FAIL flush_fill: got valid=%b ready=%b want 1 0", dec_valid_o, ifu_ready_o);
      end
      ifu_pc_i = 64'h3010;
      flush_i  = 1'b1;
      tick();
      flush_i     = 1'b0;
      ifu_valid_i = 1'b0;
      checks++;
      if (dec_valid_o !== 1'b0 || ifu_ready_o !== 1'b1) begin
         fails++;
         $display("FAIL flush_full: got valid=%b ready=%b want 0 1", dec_valid_o, ifu_ready_o);
      end
      dec_ready_i = 1'b1;
      tick();
      tick();
      checks++;
      if (dec_valid_o !== 1'b0) begin fails++; $display("FAIL flush_ghost: got %b want 0", dec_valid_o); end
      ifu_valid_i = 1'b1;
      ifu_inst_i  = 32'h800082B7;
      ifu_pc_i    = 64'h3014;
      tick();
      ifu_valid_i = 1'b0;
      checks++;
      if (dec_valid_o !== 1'b1 || dec_pc_o !== 64'h3014 || dec_opcode_o !== LUI) begin
         fails++;
         $display("FAIL flush_resume: got valid=%b pc=%h op=%0d want 1 3014 LUI", dec_valid_o, dec_pc_o, dec_opcode_o);
      end
      tick();
      checks++;
      if (dec_valid_o !== 1'b0) begin fails++; $display("FAIL flush_single: got %b want 0", dec_valid_o); end
   endtask

   task automatic test_async_reset();
      dec_ready_i = 1'b0;
      ifu_valid_i = 1'b1;
      ifu_inst_i  = 32'hfff10093;
      ifu_pc_i    = 64'h4000;
      tick();
      ifu_pc_i = 64'h4004;
      tick();
      ifu_valid_i = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (dec_valid_o !== 1'b0 || ifu_ready_o !== 1'b1 || dec_pc_o !== '0 || dec_opcode_o !== NONE) begin
         fails++;
         $display("FAIL async_reset: got valid=%b ready=%b pc=%h op=%0d want 0 1 0 NONE", dec_valid_o, ifu_ready_o, dec_pc_o, dec_opcode_o);
      end
      tick();
      #2 rst_n = 1'b1;
      dec_ready_i = 1'b1;
      tick();
      tick();
      checks++;
      if (dec_valid_o !== 1'b0 || ifu_ready_o !== 1'b1) begin
         fails++;
         $display("FAIL async_release: got valid=%b ready=%b want 0 1", dec_valid_o, ifu_ready_o);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_decode();
      test_backpressure();
      test_flush();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/mercury_decode.md
# mercury_decode

Instruction decode stage for the Mercury RV64I core. It accepts 32-bit instructions and PCs from the fetch unit over a valid/ready handshake and classifies each into an `opcode1_t`. It extracts logical register indices into a `uop_info_t`, builds the sign-extended immediate, and presents the result to the downstream rename/dispatch stage. A two-entry output buffer (main + skid) gives full throughput under backpressure with registered ready.

## Interface
- `PC_W`, 64, PC width in bits.
- `clk`  in  1  core clock, rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush_i`  in  1  discard all buffered and incoming instructions.
- `ifu_valid_i`  in  1  fetch presents an instruction.
- `ifu_ready_o`  out  1  decode can accept; driven directly by a flop.
- `ifu_inst_i`  in  32  raw instruction.
- `ifu_pc_i`  in  PC_W  instruction PC.
- `dec_valid_o`  out  1  decoded uop valid.
- `dec_ready_i`  in  1  downstream accepts.
- `dec_opcode_o`  out  opcode1_t  fine-grained operation; `NONE` when illegal.
- `dec_uop_o`  out  uop_info_t  {lsrc1, lsrc2, ldst}.
- `dec_imm_o`  out  64  sign-extended immediate.
- `dec_pc_o`  out  PC_W  PC of the decoded instruction.
- `dec_illegal_o`  out  1  encoding not recognised.

## Operation
- Decode is combinational on `ifu_inst_i`, with major opcode `[6:0]`, `funct3`, and `funct7`.
  - LUI, AUIPC, JAL, JALR, and BRANCH map to BEQ..BGEU.
  - LOAD maps to LB..LD, and STORE maps to SB..SD.
  - OP-IMM, OP-IMM-32, OP, and OP-32 map to the ALU entries.
  - MISC-MEM maps to FENCE, and to FENCE_TSO when `fm=1000` and pred/succ=RW,RW. PAUSE is FENCE with pred=W, succ=0, rs1=rd=0.
  - SYSTEM maps to ENV.
- Any unmatched encoding, including a wrong `funct7` or shamt[5]=1 on a `*W` shift, produces `NONE` with `dec_illegal_o=1`. Its fields are still captured.
- `lsrc1=inst[19:15]`, `lsrc2=inst[24:20]`, `ldst=inst[11:7]`. A field is forced to 0 when the format does not use it:
  - lsrc1 is 0 for U/J formats.
  - lsrc2 is 0 for U/J/I formats.
  - ldst is 0 for S/B formats, FENCE, and ENV.
- `dec_imm_o` by format:
  - I: inst[31:20] sign-extended; shifts give a zero-extended shamt.
  - S: {inst[31:25],inst[11:7]}.
  - B: {inst[31],inst[7],inst[30:25],inst[11:8],0}.
  - U: {inst[31:12],12'b0} sign-extended to 64 bits.
  - J: {inst[31],inst[19:12],inst[20],inst[30:21],0}.
  - R/FENCE/ENV: 0.
- Buffering: a main output register plus one skid register.
  - Accept occurs when `ifu_valid_i & ifu_ready_o`.
  - If main is empty, or main is draining this cycle with skid empty, the new entry goes to main. Otherwise it goes to skid.
  - When main drains and skid is full, skid moves to main.
  - `ifu_ready_o` next value is `!(skid full next)`.
- Flush: both entries are invalidated at the next edge. Any instruction accepted in the same cycle is dropped. `ifu_ready_o` returns to 1. Flush has priority over accept and drain.

## Timing
- Reset values: `dec_valid_o=0` and `ifu_ready_o=1`. `dec_opcode_o=NONE`, `dec_uop_o=0`, `dec_imm_o=0`, `dec_pc_o=0`, `dec_illegal_o=0`.
- Latency: an instruction accepted at edge N is visible on `dec_*` after edge N, one cycle.
- Throughput: one instruction per cycle with continuous `dec_ready_i=1`.
- Output stability: while `dec_valid_o=1 & !dec_ready_i`, all `dec_*` outputs hold constant.
- Backpressure: after `dec_ready_i` drops, at most one more instruction is accepted (into skid). `ifu_ready_o` then deasserts the following cycle.
- Simultaneous accept, drain, and full skid: skid moves to main, the new entry goes to skid, and ready stays 0.
- Reset asserted mid-operation clears all state asynchronously. No partial uop is emitted after release.

## Configuration
- `MERCURY_DECODE_RV64_EN` defined: LWU, LD, SD, ADDIW, SLLIW, SRLIW, SRAIW, ADDW, SUBW, SLLW, SRLW, and SRAW decode normally. Shift shamt is 6 bits.
- Not defined (RV32I subset): those encodings, OP-IMM-32, and OP-32 decode as illegal. Shifts with shamt[5]=1 are illegal.

## Test plan
- ADDI x1,x2,-1 `0xfff10093` -> next cycle `dec_valid_o=1`, ADDI, lsrc1=2, lsrc2=0, ldst=1, imm=`0xFFFF_FFFF_FFFF_FFFF`.
- SW x5,8(x6) `0x00532423` -> SW, lsrc1=6, lsrc2=5, ldst=0, imm=8.
- LD x3,0(x4) `0x00023183` -> LD, lsrc1=4, ldst=3 with the macro; `NONE` with illegal=1 without it.
- `0x00000000` -> `NONE`, `dec_illegal_o=1`, `dec_valid_o=1`.
- Stream of 4 instructions with `dec_ready_i=0` from cycle 1:
  - Exactly 2 are accepted, and `ifu_ready_o=0` from cycle 3.
  - After `dec_ready_i=1`, they are delivered in order, one per cycle, with no loss or duplication.
- Main and skid full, then `flush_i=1` with `ifu_valid_i=1`: next cycle `dec_valid_o=0` and `ifu_ready_o=1`, and the flushed-cycle instruction never appears.
